// File: rtl/dmp_periph_ctrl.sv
// Shares the DMP peripheral load/store port between up to four slots, one access at a time.
// Optional macro DMP_PERIPH_TIMEOUT_EN enables the bounded-wait timeout on BUSY.
module dmp_periph_ctrl #(
  parameter int          NUM_SLOTS = 2,
  parameter logic [31:0] BASE_ADDR = 32'hFF00_0000,
  parameter int          WIN_BITS  = 16,
  parameter int          SLOT_LSB  = 12,
  parameter int          TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst_a,
  input  logic                      ld_req,
  input  logic                      st_req,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      p_ldvalid,
  output logic [31:0]               p_drd,
  output logic                      p_stall,
  output logic                      p_err,
  output logic [NUM_SLOTS-1:0]      ps_sel,
  output logic                      ps_we,
  output logic [31:0]               ps_addr,
  output logic [31:0]               ps_wdata,
  input  logic [NUM_SLOTS-1:0]      ps_ack,
  input  logic [32*NUM_SLOTS-1:0]   ps_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  if (NUM_SLOTS < 1 || NUM_SLOTS > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("dmp_periph_ctrl: NUM_SLOTS or TIMEOUT out of range");
  end

  state_e                state_q;
  logic [1:0]            slot_q;
  logic                  is_load_q;
  logic                  ps_we_q;
  logic [31:0]           ps_addr_q;
  logic [31:0]           ps_wdata_q;
  logic [NUM_SLOTS-1:0]  ps_sel_q;
  logic                  p_ldvalid_q;
  logic [31:0]           p_drd_q;
  logic                  p_err_q;
`ifdef DMP_PERIPH_TIMEOUT_EN
  logic [7:0]            cnt_q;
`endif

  logic                  hit;
  logic [1:0]            req_slot;
  logic                  slot_bad;
  logic [NUM_SLOTS-1:0]  sel_onehot;
  logic                  ack_hit;
  logic [31:0]           rdata_sel;

  assign hit      = (ld_req | st_req) && (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign req_slot = addr[SLOT_LSB+1:SLOT_LSB];
  assign slot_bad = ({1'b0, req_slot} >= 3'(NUM_SLOTS));

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sel_onehot = '0;
    ack_hit    = 1'b0;
    rdata_sel  = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      sel_onehot[k] = (req_slot == 2'(k));
      if (slot_q == 2'(k)) begin
        ack_hit   = ps_ack[k];
        rdata_sel = ps_rdata[32*k +: 32];
      end
    end
  end

  // Stall rises combinationally in the hit cycle so the DMP holds before BUSY is entered.
  assign p_stall = ((state_q == IDLE) && hit) || (state_q == BUSY);

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      is_load_q   <= 1'b0;
      ps_we_q     <= 1'b0;
      ps_addr_q   <= '0;
      ps_wdata_q  <= '0;
      ps_sel_q    <= '0;
      p_ldvalid_q <= 1'b0;
      p_drd_q     <= '0;
      p_err_q     <= 1'b0;
`ifdef DMP_PERIPH_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      p_ldvalid_q <= 1'b0;
      p_drd_q     <= '0;
      p_err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            ps_addr_q  <= addr;
            ps_wdata_q <= wdata;
            ps_we_q    <= st_req & ~ld_req;
            is_load_q  <= ld_req;
            slot_q     <= req_slot;
            if (slot_bad) begin
              state_q     <= DONE;
              p_ldvalid_q <= ld_req;
              p_err_q     <= 1'b1;
            end else begin
              state_q  <= BUSY;
              ps_sel_q <= sel_onehot;
`ifdef DMP_PERIPH_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end
          end
        end
        BUSY: begin
          // An ack arriving together with the timeout still completes cleanly.
          if (ack_hit) begin
            state_q     <= DONE;
            ps_sel_q    <= '0;
            p_ldvalid_q <= is_load_q;
            p_drd_q     <= is_load_q ? rdata_sel : 32'h0;
          end
`ifdef DMP_PERIPH_TIMEOUT_EN
          else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
            state_q     <= DONE;
            ps_sel_q    <= '0;
            p_ldvalid_q <= is_load_q;
            p_err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps_sel    = ps_sel_q;
  assign ps_we     = ps_we_q;
  assign ps_addr   = ps_addr_q;
  assign ps_wdata  = ps_wdata_q;
  assign p_ldvalid = p_ldvalid_q;
  assign p_drd     = p_drd_q;
  assign p_err     = p_err_q;

endmodule

// File: doc/dmp_periph_ctrl.md
Name: dmp_periph_ctrl

Overview:
- Controller that shares the DMP peripheral load/store port between up to 4 customer peripheral slots.
- Decodes the peripheral address window and sequences one access at a time.
- Holds the pipeline via p_stall and returns load data on p_ldvalid/p_drd.
- Sits between the DMP load/store unit and the peripheral add-ons; has a bounded-wait timeout.

Parameters:
- NUM_SLOTS, 2, number of peripheral slots, 1..4.
- BASE_ADDR, 32'hFF00_0000, peripheral window base; compared on bits [31:WIN_BITS].
- WIN_BITS, 16, window size as log2 bytes.
- SLOT_LSB, 12, slot index taken from addr[SLOT_LSB+1:SLOT_LSB].
- TIMEOUT, 15, max BUSY cycles before forced completion, 1..255.

Ports:
- clk  in  1  core clock.
- rst_a  in  1  reset; synchronous, active-low.
- ld_req  in  1  load request from DMP, 1-cycle qualifier.
- st_req  in  1  store request from DMP, 1-cycle qualifier.
- addr  in  32  request byte address.
- wdata  in  32  store data.
- p_ldvalid  out  1  load data valid, 1-cycle pulse.
- p_drd  out  32  load return data.
- p_stall  out  1  stall to DMP.
- p_err  out  1  decode-error or timeout, 1-cycle pulse.
- ps_sel  out  NUM_SLOTS  one-hot slot select, held for the whole access.
- ps_we  out  1  1 = store.
- ps_addr  out  32  registered address.
- ps_wdata  out  32  registered store data.
- ps_ack  in  NUM_SLOTS  per-slot completion.
- ps_rdata  in  32*NUM_SLOTS  per-slot read data; slot k is bits [32k+31:32k].

Behaviour:
- Reset (rst_a=0 at clk edge): state IDLE; all outputs 0; ps_addr/ps_wdata 0; timeout counter 0. Reset mid-access abandons the access: ps_sel drops on that edge and no p_ldvalid/p_err is issued.
- Hit condition: (ld_req|st_req) and addr[31:WIN_BITS]==BASE_ADDR[31:WIN_BITS]. Misses are ignored entirely; outputs stay 0.
- Simultaneous ld_req and st_req: treated as a load; st_req is dropped.
- State IDLE:
  - On a hit, latch addr, wdata, we, slot; go to BUSY.
  - p_stall is driven combinationally high in the hit cycle.
  - If slot >= NUM_SLOTS, go to DONE with err_flag=1 instead.
- State BUSY:
  - ps_sel[slot]=1; ps_we/ps_addr/ps_wdata stable; p_stall=1; counter increments each cycle.
  - ps_ack[slot]=1: capture ps_rdata slot word; go to DONE.
  - Acks from unselected slots are ignored.
  - Counter reaching TIMEOUT with no ack: go to DONE with err_flag=1 and captured data 0.
  - An ack in the same cycle the counter reaches TIMEOUT wins; no error.
- State DONE (1 cycle):
  - ps_sel=0; p_stall=0.
  - Load: p_ldvalid=1 and p_drd=captured data.
  - Store: p_ldvalid=0.
  - p_err=err_flag.
  - Next state IDLE unconditionally; requests in DONE are ignored. Min access = 3 cycles (hit, BUSY, DONE).
- p_drd is 0 whenever p_ldvalid=0.
- The counter clears on entry to BUSY and is 8 bits wide.

Optional Feature:
- Macro DMP_PERIPH_TIMEOUT_EN.
- Defined: timeout counter and forced completion as above.
- Undefined: no counter; BUSY waits indefinitely for ps_ack; p_err is raised only by decode error; the TIMEOUT parameter is unused.

Test Plan:
- Load slot 1: ld_req, addr=32'hFF00_1004 -> ps_sel=2'b10 and ps_addr=32'hFF00_1004 from next cycle. ps_ack[1] with rdata 32'hCAFE_0001 after 3 BUSY cycles -> next cycle p_ldvalid=1, p_drd=32'hCAFE_0001, p_stall=0, p_err=0.
- Store slot 0: st_req, addr=32'hFF00_0010, wdata=32'h1234_5678 -> ps_we=1, ps_wdata=32'h1234_5678. Immediate ack -> DONE with p_ldvalid=0, p_err=0.
- Decode error, NUM_SLOTS=2: ld_req addr=32'hFF00_3000 -> ps_sel stays 0; next cycle p_ldvalid=1, p_drd=0, p_err=1.
- Timeout, macro defined, TIMEOUT=15: load, no ack -> p_stall high for 16 cycles (hit + 15 BUSY), then p_err=1 and p_drd=0. Macro undefined: stall persists until ack.
- Unselected ack and miss: during slot-0 access, ps_ack[1]=1 -> ignored. ld_req at addr=32'h0000_1000 -> no stall, no select.
- Mid-access reset: rst_a=0 during BUSY -> next edge ps_sel=0, p_stall=0, no p_ldvalid. A load after release completes normally.
